wb_stream_bridge: RTL and testbench
===================================

WB_STREAM_BRIDGE -- requirements
Module: wb_stream_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: decoded when wbs_adr_i[31:8] == BASE_ADDR[31:8].
REQ-002 SHALL have parameter DATA_W, default 32, legal 1..32: stream payload width.
REQ-003 SHALL have parameter TX_DEPTH, default 4, power of two >= 2: TX FIFO entries.
REQ-004 SHALL have parameter RX_DEPTH, default 4, power of two >= 2: RX FIFO entries.
REQ-005 SHALL have port wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-008 SHALL have ports wbs_sel_i  in  4 and wbs_adr_i  in  32 and wbs_dat_i  in  32  byte selects, address, write data.
REQ-009 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  acknowledge, read data.
REQ-010 SHALL have ports tx_valid_o  out  1, tx_data_o  out  DATA_W, tx_ready_i  in  1  outbound stream to user logic.
REQ-011 SHALL have ports rx_valid_i  in  1, rx_data_i  in  DATA_W, rx_ready_o  out  1  inbound stream from user logic.
REQ-012 SHALL have port irq  out  3  [0] RX not empty, [1] TX empty, [2] error sticky, each masked by IRQ_EN.

Function
REQ-013 SHALL decode word offsets wbs_adr_i[7:2]: 0 TX_DATA (W), 1 RX_DATA (R), 2 STATUS (R, W1C), 3 IRQ_EN (RW, bits [2:0]); other offsets read 0, writes ignored, still acked.
REQ-014 SHALL raise wbs_ack_o for exactly one cycle, registered, one cycle after cyc&stb on a decoded address; wbs_ack_o SHALL be 0 for undecoded addresses.
REQ-015 SHALL hold wbs_ack_o low on any access while a previous ack is high (no back-to-back ack from one strobe).
REQ-016 SHALL, on TX_DATA write with TX FIFO not full, push wbs_dat_i[DATA_W-1:0] and ack next cycle; sel ignored on TX_DATA.
REQ-017 SHALL, on TX_DATA write with TX FIFO full, withhold ack (stall) until one entry is popped, then push and ack the following cycle.
REQ-018 SHALL, on RX_DATA read with RX FIFO non-empty, return head zero-extended to 32 bits and pop it in the ack cycle.
REQ-019 SHALL, on RX_DATA read with RX FIFO empty, ack with data 0 and set STATUS.underflow.
REQ-020 SHALL present STATUS as {23'b0, underflow[8], overflow[7], rx_count[6:4] saturating, tx_count[3:1] saturating, tx_full[0]}; counts saturate at 7.
REQ-021 SHALL drive tx_valid_o = TX not empty, tx_data_o = TX head; pop on tx_valid_o & tx_ready_i.
REQ-022 SHALL drive rx_ready_o = 1; push on rx_valid_i when RX not full; rx_valid_i while RX full SHALL drop the beat and set STATUS.overflow.
REQ-023 SHALL support simultaneous push and pop on either FIFO in one cycle, count unchanged, including when full (pop frees slot same cycle only for TX stream pop + bus push).
REQ-024 SHALL wrap FIFO pointers modulo depth with one extra bit for full/empty distinction.
REQ-025 SHALL clear sticky bits only by writing 1 to the bit in STATUS with wbs_sel_i[1] set; a set event in the same cycle as clear wins.
REQ-026 SHALL register irq outputs: irq[i] = IRQ_EN[i] & condition[i], one cycle after the condition changes.
REQ-027 SHALL honour wbs_sel_i[0] for IRQ_EN writes; other byte lanes ignored.

Reset
REQ-028 SHALL, with wb_rst_i high at a clock edge, empty both FIFOs, clear sticky bits and IRQ_EN, drive wbs_ack_o=0, wbs_dat_o=0, tx_valid_o=0, irq=0; rx_ready_o SHALL be 0 during reset.
REQ-029 SHALL abort any stalled bus write on reset without ack; transaction SHALL be reissued by master.

Verification
REQ-030 SHALL cover: write 0xA5 to TX_DATA, tx_ready_i=1 -> ack 1 cycle later, tx_valid_o=1 with tx_data_o=0xA5 for 1 cycle.
REQ-031 SHALL cover: tx_ready_i=0, 5 TX writes at depth 4 -> 4 acks, 5th stalls; raise tx_ready_i -> 5th acks within 2 cycles, order preserved.
REQ-032 SHALL cover: 5 rx beats 1..5 at depth 4 -> STATUS reads 0x0C0 range with overflow=1; RX reads return 1,2,3,4, then 0 with underflow=1.
REQ-033 SHALL cover: IRQ_EN=0x1, one rx beat -> irq[0]=1 next+1 cycle; RX read -> irq[0]=0; write STATUS 0x180 -> sticky bits 0.
REQ-034 SHALL cover: wb_rst_i asserted during stalled TX write with 4 entries queued -> no ack, tx_valid_o=0, STATUS=0 next cycle.
REQ-035 SHALL cover: access at BASE_ADDR+0x100 -> no ack; offset 0x20 -> ack, read 0.

Source files
------------

// File: rtl/wb_stream_bridge.sv
// Wishbone classic slave bridging a register window onto a pair of valid/ready streams.
// TX_DATA writes feed an outbound FIFO; inbound beats land in an RX FIFO drained by RX_DATA reads.
module wb_stream_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TX_DEPTH  = 4,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              tx_ready_i,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic [2:0]        irq
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);

    localparam logic [5:0] OFF_TX_DATA = 6'd0;
    localparam logic [5:0] OFF_RX_DATA = 6'd1;
    localparam logic [5:0] OFF_STATUS  = 6'd2;
    localparam logic [5:0] OFF_IRQ_EN  = 6'd3;

    // FIFO storage and pointers (extra MSB separates full from empty)
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW:0]    tx_wr_ptr, tx_rd_ptr, tx_count;
    logic [RX_AW:0]    rx_wr_ptr, rx_rd_ptr, rx_count;
    logic              tx_empty, tx_full, rx_empty, rx_full;

    logic              ack_q;
    logic [31:0]       dat_q;
    logic [2:0]        irq_en;
    logic [2:0]        irq_q;
    logic              overflow, underflow;

    logic              hit_c, bus_req_c, accept_c;
    logic [5:0]        off_c;
    logic              tx_wr_req_c, tx_push_c, tx_pop_c;
    logic              rx_rd_c, rx_pop_c, rx_push_c;
    logic              ovf_set_c, udf_set_c, status_wr_c, irq_en_wr_c;
    logic [2:0]        tx_count_sat, rx_count_sat;
    logic [2:0]        irq_cond_c;
    logic [31:0]       rdata_c;
    logic              unused_c;

    assign tx_count = tx_wr_ptr - tx_rd_ptr;
    assign rx_count = rx_wr_ptr - rx_rd_ptr;
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);

    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_mem[tx_rd_ptr[TX_AW-1:0]];
    assign rx_ready_o = ~wb_rst_i;
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign irq        = irq_q;

    // Bus decode; a live ack blocks re-acceptance of the same strobe
    assign off_c     = wbs_adr_i[7:2];
    assign hit_c     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign bus_req_c = wbs_cyc_i & wbs_stb_i & hit_c & ~ack_q & ~wb_rst_i;

    // A full TX FIFO stalls the write unless the stream drains a slot this cycle
    assign tx_pop_c    = tx_valid_o & tx_ready_i & ~wb_rst_i;
    assign tx_wr_req_c = bus_req_c & wbs_we_i & (off_c == OFF_TX_DATA);
    assign tx_push_c   = tx_wr_req_c & (~tx_full | tx_pop_c);
    assign accept_c    = bus_req_c & ~(tx_wr_req_c & ~tx_push_c);

    assign rx_rd_c   = accept_c & ~wbs_we_i & (off_c == OFF_RX_DATA);
    assign rx_pop_c  = rx_rd_c & ~rx_empty;
    assign udf_set_c = rx_rd_c & rx_empty;
    assign rx_push_c = rx_valid_i & rx_ready_o & ~rx_full;
    assign ovf_set_c = rx_valid_i & rx_ready_o & rx_full;

    assign status_wr_c = accept_c & wbs_we_i & (off_c == OFF_STATUS) & wbs_sel_i[1];
    assign irq_en_wr_c = accept_c & wbs_we_i & (off_c == OFF_IRQ_EN) & wbs_sel_i[0];

    assign irq_cond_c = {overflow | underflow, tx_empty, ~rx_empty};

    assign unused_c = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i};

    // Occupancy fields in STATUS are 3 bits and clamp at 7
    always_comb begin
        tx_count_sat = 3'd7;
        rx_count_sat = 3'd7;
        if (32'(tx_count) <= 32'd7) begin
            tx_count_sat = 3'(tx_count);
        end
        if (32'(rx_count) <= 32'd7) begin
            rx_count_sat = 3'(rx_count);
        end
    end

    always_comb begin
        rdata_c = '0;
        case (off_c)
            OFF_RX_DATA: begin
                if (!rx_empty) begin
                    rdata_c = 32'(rx_mem[rx_rd_ptr[RX_AW-1:0]]);
                end
            end
            OFF_STATUS:  rdata_c = {23'b0, underflow, overflow, rx_count_sat, tx_count_sat, tx_full};
            OFF_IRQ_EN:  rdata_c = {29'b0, irq_en};
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_push_c) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= wbs_dat_i[DATA_W-1:0];
        end
        if (rx_push_c) begin
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_data_i;
        end
    end

    // Control state; sticky set events take priority over a same-cycle clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_en    <= '0;
            irq_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ack_q <= accept_c;
            dat_q <= (accept_c && !wbs_we_i) ? rdata_c : 32'd0;
            if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
            if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + (TX_AW+1)'(1);
            if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
            if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
            overflow  <= ovf_set_c | (overflow  & ~(status_wr_c & wbs_dat_i[7]));
            underflow <= udf_set_c | (underflow & ~(status_wr_c & wbs_dat_i[8]));
            if (irq_en_wr_c) irq_en <= wbs_dat_i[2:0];
            irq_q <= irq_en & irq_cond_c;
        end
    end

endmodule

// File: tb/tb_wb_stream_bridge.sv
// Directed bench for wb_stream_bridge: scoreboards for the TX stream and for bus read data.
module tb_wb_stream_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] rdat;
    logic        tx_valid, tx_ready;
    logic [31:0] tx_data;
    logic        rx_valid, rx_ready;
    logic [31:0] rx_data;
    logic [2:0]  irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    wb_stream_bridge #(
        .BASE_ADDR (BASE),
        .DATA_W    (32),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Stream scoreboard: every handshake must match the oldest queued TX write
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) check("tx_unexpected_beat", 32'(tx_valid), 32'd0);
            else                  check("tx_stream_data", tx_data, tx_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        int n;
        drive(1'b1, a, d, s);
        wait_ack(8, n);
        idle();
        check({tag, "_ack"}, 32'(n != 0), 32'd1);
    endtask

    task automatic wr_tx(input logic [31:0] d, input string tag);
        tx_q.push_back(d);
        wr(BASE, d, 4'hF, tag);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        int n;
        rd_q.push_back(exp);
        drive(1'b0, a, 32'd0, 4'hF);
        wait_ack(8, n);
        check({tag, "_ack"}, 32'(n != 0), 32'd1);
        if (n != 0) check(tag, rdat, rd_q.pop_front());
        else        void'(rd_q.pop_front());
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        idle();
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("rx_ready_run", 32'(rx_ready), 32'd1);

        // Single TX write streams straight out
        tx_ready = 1'b1;
        tx_q.push_back(32'hA5);
        drive(1'b1, BASE, 32'hA5, 4'h0);
        wait_ack(4, n);
        check("tx_ack_latency", 32'(n), 32'd1);
        check("tx_valid_up", 32'(tx_valid), 32'd1);
        check("tx_data_a5", tx_data, 32'hA5);
        idle();
        tick();
        check("tx_valid_one_cycle", 32'(tx_valid), 32'd0);

        // Fill TX, stall the fifth write, release with tx_ready
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr_tx(32'h10 + 32'(i), "tx_fill");
        rd(BASE + 32'h8, 32'h009, "status_tx_full");
        tx_q.push_back(32'h15);
        drive(1'b1, BASE, 32'h15, 4'hF);
        wait_ack(4, n);
        check("tx_stall_no_ack", 32'(n), 32'd0);
        tx_ready = 1'b1;
        wait_ack(2, n);
        check("tx_stall_release", 32'(n != 0), 32'd1);
        idle();
        repeat (6) tick();
        check("tx_drained_valid", 32'(tx_valid), 32'd0);
        check("tx_drained_queue", 32'(tx_q.size()), 32'd0);

        // RX overflow then underflow
        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 32'(i);
            tick();
        end
        rx_valid = 1'b0;
        rd(BASE + 32'h8, 32'h0C0, "status_rx_ovf");
        for (int i = 1; i <= 4; i++) rd(BASE + 32'h4, 32'(i), "rx_data");
        rd(BASE + 32'h4, 32'd0, "rx_empty_read");
        rd(BASE + 32'h8, 32'h180, "status_sticky");
        wr(BASE + 32'h8, 32'h180, 4'b0001, "status_w1c_nosel");
        rd(BASE + 32'h8, 32'h180, "status_kept");
        wr(BASE + 32'h8, 32'h180, 4'b0010, "status_w1c");
        rd(BASE + 32'h8, 32'h000, "status_cleared");

        // IRQ enable, RX-not-empty interrupt and sticky error interrupt
        wr(BASE + 32'hC, 32'h1, 4'b0001, "irq_en_wr");
        rd(BASE + 32'hC, 32'h1, "irq_en_rd");
        wr(BASE + 32'hC, 32'h7, 4'b1110, "irq_en_nosel");
        rd(BASE + 32'hC, 32'h1, "irq_en_kept");
        check("irq_idle", 32'(irq), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 32'h77;
        tick();
        rx_valid = 1'b0;
        check("irq_not_yet", 32'(irq), 32'd0);
        tick();
        check("irq_rx", 32'(irq), 32'd1);
        rd(BASE + 32'h4, 32'h77, "rx_irq_data");
        tick();
        check("irq_rx_clear", 32'(irq), 32'd0);
        rd(BASE + 32'h4, 32'd0, "rx_underflow_read");
        wr(BASE + 32'hC, 32'h7, 4'b0001, "irq_en_all");
        tick();
        check("irq_err_txe", 32'(irq), 32'h6);
        wr(BASE + 32'h8, 32'h180, 4'b0010, "status_clr2");
        rd(BASE + 32'h8, 32'h000, "status_cleared2");
        check("irq_err_gone", 32'(irq), 32'h2);
        wr(BASE + 32'hC, 32'h0, 4'b0001, "irq_en_off");

        // Reset during a stalled TX write
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr_tx(32'h20 + 32'(i), "tx_fill2");
        drive(1'b1, BASE, 32'h25, 4'hF);
        wait_ack(3, n);
        check("rst_stall_no_ack", 32'(n), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_abort_ack", 32'(ack), 32'd0);
        check("rst_abort_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_abort_irq", 32'(irq), 32'd0);
        check("rst_abort_rx_ready", 32'(rx_ready), 32'd0);
        idle();
        rst = 1'b0;
        tx_q.delete();
        tick();
        rd(BASE + 32'h8, 32'h000, "status_after_rst");
        rd(BASE + 32'hC, 32'h000, "irq_en_after_rst");
        check("tx_valid_after_rst", 32'(tx_valid), 32'd0);

        // Address decode boundaries
        drive(1'b0, BASE + 32'h100, 32'd0, 4'hF);
        wait_ack(4, n);
        idle();
        check("undecoded_rd_no_ack", 32'(n), 32'd0);
        tick();
        drive(1'b1, BASE + 32'h104, 32'hFF, 4'hF);
        wait_ack(4, n);
        idle();
        check("undecoded_wr_no_ack", 32'(n), 32'd0);
        tick();
        rd(BASE + 32'h20, 32'd0, "offset20_rd");
        wr(BASE + 32'h20, 32'hDEAD_BEEF, 4'hF, "offset20_wr");
        rd(BASE, 32'd0, "tx_data_rd_zero");
        rd(BASE + 32'h8, 32'h000, "status_final");

        repeat (4) tick();
        check("tx_queue_final", 32'(tx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
